// File: rtl/minsoc_clkdiv_pkg.sv
// rtl/minsoc_clkdiv_pkg.sv - shared state encodings and constants for the clock divider bank
package minsoc_clkdiv_pkg;

    typedef enum logic [1:0] {
        CLKDIV_OFF      = 2'd0,
        CLKDIV_RUN      = 2'd1,
        CLKDIV_STOPPING = 2'd2
    } clkdiv_state_e;

    // Smallest divisor that still yields a real high and low phase.
    localparam int unsigned CLKDIV_MIN_DIV = 2;

endpackage

// File: rtl/minsoc_clkdiv_channel.sv
// rtl/minsoc_clkdiv_channel.sv - one glitch-free programmable divider channel
module minsoc_clkdiv_channel
    import minsoc_clkdiv_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic             div_load_i,
    output logic             clk_o,
    output logic             stb_o,
    output logic             pending_o,
    output logic             running_o
);

    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(CLKDIV_MIN_DIV);
    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    clkdiv_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             clk_q, clk_d;
    logic             stb_q, stb_d;

    logic [CNT_W-1:0] div_clamped;
    logic [CNT_W-1:0] half_d;
    logic             wrap;
    logic             run_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        act_d       = act_q;
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        div_clamped = (div_i < MIN_DIV) ? MIN_DIV : div_i;
        wrap        = (state_q != CLKDIV_OFF) && (cnt_q == act_q - CNT_W'(1));

        case (state_q)
            CLKDIV_OFF: begin
                if (div_load_i) begin
                    act_d    = div_clamped;
                    shadow_d = div_clamped;
                end
                cnt_d = '0;
                if (en_i) begin
                    state_d = CLKDIV_RUN;
                end
            end
            default: begin
                // Divisor changes only ever land on a period boundary.
                if (div_load_i && wrap) begin
                    act_d     = div_clamped;
                    shadow_d  = div_clamped;
                    pending_d = 1'b0;
                end else if (div_load_i) begin
                    shadow_d  = div_clamped;
                    pending_d = 1'b1;
                end else if (wrap && pending_q) begin
                    act_d     = shadow_q;
                    pending_d = 1'b0;
                end
                cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
                if (en_i) begin
                    state_d = CLKDIV_RUN;
                end else if (wrap) begin
                    state_d = CLKDIV_OFF;
                end else begin
                    state_d = CLKDIV_STOPPING;
                end
            end
        endcase

        half_d = (act_d >> 1) + {{(CNT_W-1){1'b0}}, act_d[0]};
        run_d  = (state_d != CLKDIV_OFF);
        clk_d  = run_d && (cnt_d < half_d);
        stb_d  = run_d && (cnt_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= CLKDIV_OFF;
            cnt_q     <= '0;
            act_q     <= DEF_DIV;
            shadow_q  <= DEF_DIV;
            pending_q <= 1'b0;
            clk_q     <= 1'b0;
            stb_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            act_q     <= act_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            clk_q     <= clk_d;
            stb_q     <= stb_d;
        end
    end

    assign clk_o     = clk_q;
    assign stb_o     = stb_q;
    assign pending_o = pending_q;
    assign running_o = (state_q != CLKDIV_OFF);

endmodule

// File: rtl/minsoc_clkdiv_bank.sv
// rtl/minsoc_clkdiv_bank.sv - bank of independent run-time programmable clock dividers
module minsoc_clkdiv_bank
    import minsoc_clkdiv_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic [NUM_CH*CNT_W-1:0] div_i,
    input  logic [NUM_CH-1:0]       div_load_i,
    output logic [NUM_CH-1:0]       clk_o,
    output logic [NUM_CH-1:0]       stb_o,
    output logic [NUM_CH-1:0]       pending_o,
    output logic [NUM_CH-1:0]       running_o
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        minsoc_clkdiv_channel #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .en_i      (en_i[c]),
            .div_i     (div_i[c*CNT_W +: CNT_W]),
            .div_load_i(div_load_i[c]),
            .clk_o     (clk_o[c]),
            .stb_o     (stb_o[c]),
            .pending_o (pending_o[c]),
            .running_o (running_o[c])
        );
    end

endmodule

// File: tb/tb_minsoc_clkdiv_bank.sv
// tb/tb_minsoc_clkdiv_bank.sv - self-checking bench for minsoc_clkdiv_bank
module tb_minsoc_clkdiv_bank;

    localparam int NCH = 4;
    localparam int CW  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    en;
    logic [NCH*CW-1:0] div;
    logic [NCH-1:0]    load;
    logic [NCH-1:0]    clk_o, stb_o, pending_o, running_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    minsoc_clkdiv_bank dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .div_i     (div),
        .div_load_i(load),
        .clk_o     (clk_o),
        .stb_o     (stb_o),
        .pending_o (pending_o),
        .running_o (running_o)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each channel is a period of length per, a position within it, and a run mode.
    int m_mode[NCH];   // 0 idle, 1 running, 2 finishing last period
    int m_pos[NCH];
    int m_per[NCH];
    int m_shadow[NCH];
    bit m_pend[NCH];
    bit m_clk[NCH];
    bit m_stb[NCH];

    function automatic int clampv(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (rst) begin
                m_mode[c] = 0; m_pos[c] = 0; m_per[c] = 4; m_shadow[c] = 4; m_pend[c] = 0;
            end else begin
                int  dv;
                bit  boundary;
                dv = clampv(int'(div[c*CW +: CW]));
                boundary = (m_mode[c] != 0) && (m_pos[c] == m_per[c] - 1);
                if (m_mode[c] == 0) begin
                    if (load[c]) begin m_per[c] = dv; m_shadow[c] = dv; end
                    m_pos[c] = 0;
                    if (en[c]) m_mode[c] = 1;
                end else begin
                    if (load[c] && boundary) begin
                        m_per[c] = dv; m_shadow[c] = dv; m_pend[c] = 0;
                    end else if (load[c]) begin
                        m_shadow[c] = dv; m_pend[c] = 1;
                    end else if (boundary && m_pend[c]) begin
                        m_per[c] = m_shadow[c]; m_pend[c] = 0;
                    end
                    m_pos[c] = boundary ? 0 : m_pos[c] + 1;
                    if (en[c]) m_mode[c] = 1;
                    else if (boundary) m_mode[c] = 0;
                    else m_mode[c] = 2;
                end
            end
            m_clk[c] = (m_mode[c] != 0) && (m_pos[c] < (m_per[c] + 1) / 2);
            m_stb[c] = (m_mode[c] != 0) && (m_pos[c] == 0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int c = 0; c < NCH; c++) begin
                check($sformatf("model_clk%0d", c), clk_o[c], m_clk[c]);
                check($sformatf("model_stb%0d", c), stb_o[c], m_stb[c]);
                check($sformatf("model_pend%0d", c), pending_o[c], m_pend[c]);
                check($sformatf("model_run%0d", c), running_o[c], m_mode[c] != 0);
            end
        end
    end

    initial begin
        int hi, st, n;
        rst = 1'b1; en = '0; load = '0; div = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_clk", clk_o, 0);
        check("reset_stb", stb_o, 0);
        check("reset_run", running_o, 0);
        check("reset_pend", pending_o, 0);

        // T1: default divisor 4
        en[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t1_clk", clk_o[0], (i % 4) < 2);
            check("t1_stb", stb_o[0], (i % 4) == 0);
        end
        en[0] = 1'b0;
        repeat (6) @(negedge clk);
        check("t1_off", running_o[0], 0);

        // T2: odd divisor 5 loaded while idle
        div[0 +: CW] = 16'd5; load[0] = 1'b1;
        @(negedge clk);
        load[0] = 1'b0; en[0] = 1'b1;
        hi = 0; st = 0;
        repeat (10) begin
            @(negedge clk);
            hi += int'(clk_o[0]);
            st += int'(stb_o[0]);
        end
        check("t2_high_cycles", hi, 6);
        check("t2_strobes", st, 2);
        en[0] = 1'b0;
        repeat (8) @(negedge clk);

        // T3: load 6 at cnt=1 of a divide-by-4 period
        div[0 +: CW] = 16'd4; load[0] = 1'b1;
        @(negedge clk);
        load[0] = 1'b0; en[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        div[0 +: CW] = 16'd6; load[0] = 1'b1;
        @(negedge clk);
        load[0] = 1'b0;
        check("t3_pend_a", pending_o[0], 1);
        check("t3_clk_a", clk_o[0], 0);
        @(negedge clk);
        check("t3_pend_b", pending_o[0], 1);
        @(negedge clk);
        check("t3_pend_clr", pending_o[0], 0);
        check("t3_stb", stb_o[0], 1);
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            check("t3_clk6", clk_o[0], i < 3);
            check("t3_stb6", stb_o[0], 0);
        end
        @(negedge clk);
        check("t3_stb_next", stb_o[0], 1);
        en[0] = 1'b0;
        repeat (8) @(negedge clk);

        // T4: divisor 8 with coincident enable, then drop enable at cnt=0
        div[0 +: CW] = 16'd8; load[0] = 1'b1; en[0] = 1'b1;
        @(negedge clk);
        check("t4_first_stb", stb_o[0], 1);
        load[0] = 1'b0; en[0] = 1'b0;
        repeat (7) @(negedge clk);
        check("t4_still_run", running_o[0], 1);
        check("t4_low_tail", clk_o[0], 0);
        @(negedge clk);
        check("t4_stopped", running_o[0], 0);
        check("t4_no_runt", clk_o[0], 0);
        en[0] = 1'b1;
        @(negedge clk);
        en[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("t4_cnt5_clk", clk_o[0], 0);
        en[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_cont_stb", stb_o[0], 1);
        check("t4_cont_run", running_o[0], 1);
        en[0] = 1'b0;
        repeat (10) @(negedge clk);

        // T5: divisors 0 and 1 clamp to 2, then a load coincident with wrap
        div[2*CW +: CW] = 16'd0; div[3*CW +: CW] = 16'd1;
        load[3:2] = 2'b11; en[3:2] = 2'b11;
        @(negedge clk);
        load[3:2] = 2'b00;
        for (int i = 0; i < 4; i++) begin
            check("t5_div0", clk_o[2], (i % 2) == 0);
            check("t5_div1", clk_o[3], (i % 2) == 0);
            @(negedge clk);
        end
        @(negedge clk);
        div[2*CW +: CW] = 16'd3; load[2] = 1'b1;
        @(negedge clk);
        load[2] = 1'b0;
        check("t5_wrap_pend", pending_o[2], 0);
        check("t5_wrap_stb", stb_o[2], 1);
        @(negedge clk);
        check("t5_p3_stb_a", stb_o[2], 0);
        @(negedge clk);
        check("t5_p3_clk", clk_o[2], 0);
        @(negedge clk);
        check("t5_p3_stb_b", stb_o[2], 1);
        en[3:2] = 2'b00;

        // T5: full-range divisor
        div[1*CW +: CW] = 16'hFFFF; load[1] = 1'b1; en[1] = 1'b1;
        @(negedge clk);
        check("t5_max_first", stb_o[1], 1);
        load[1] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!stb_o[1] && n < 70000);
        check("t5_max_period", n, 65535);

        // T6: reset mid-period with four channels running
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; en = '0;
        div = {16'd10, 16'd7, 16'd4, 16'd3};
        load = 4'hF; en = 4'hF;
        @(negedge clk);
        load = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_clk", clk_o, 0);
        check("t6_stb", stb_o, 0);
        check("t6_pend", pending_o, 0);
        check("t6_run", running_o, 0);
        rst = 1'b0;
        @(negedge clk);
        check("t6_restart_stb", stb_o, 4'hF);
        repeat (4) @(negedge clk);
        check("t6_default_stb", stb_o, 4'hF);
        check("t6_default_clk", clk_o, 4'hF);
        repeat (2) @(negedge clk);
        check("t6_default_low", clk_o, 0);
        en = '0;
        repeat (6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
